// File: rtl/nes_cpu_pkg.sv
// Shared widths and fetch-responder state encoding for the NES CPU memory side.
package nes_cpu_pkg;

  localparam int MEM_ADDR_SIZE  = 16;
  localparam int BYTE           = 8;
  localparam int FETCH_BUNDLE_W = 3 * BYTE;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD0  = 3'd1,
    RD1  = 3'd2,
    RD2  = 3'd3,
    LAST = 3'd4,
    RESP = 3'd5
  } fetch_rsp_state_t;

endpackage

// File: rtl/imem_fetch_responder.sv
// Gathers opcode + two operand bytes from byte-wide sync memory into one bundle; 5 cycles accept->valid.
// Backpressure: bundle held in RESP until resp_ready_i; no new request accepted until then.
module imem_fetch_responder
  import nes_cpu_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [MEM_ADDR_SIZE-1:0]  req_addr_i,
  output logic                      mem_rd_en_o,
  output logic [MEM_ADDR_SIZE-1:0]  mem_addr_o,
  input  logic [BYTE-1:0]           mem_data_i,
  output logic                      resp_valid_o,
  input  logic                      resp_ready_i,
  output logic [FETCH_BUNDLE_W-1:0] resp_data_o
);

  fetch_rsp_state_t            r_state;
  fetch_rsp_state_t            w_state_nxt;
  logic [MEM_ADDR_SIZE-1:0]    r_mem_addr;
  logic [FETCH_BUNDLE_W-1:0]   r_data;

  assign req_ready_o  = (r_state == IDLE) && !flush_i;
  assign mem_rd_en_o  = (r_state == RD0) || (r_state == RD1) || (r_state == RD2);
  assign resp_valid_o = (r_state == RESP);
  assign mem_addr_o   = r_mem_addr;
  assign resp_data_o  = r_data;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (req_valid_i && req_ready_o) w_state_nxt = RD0;
      RD0:     w_state_nxt = RD1;
      RD1:     w_state_nxt = RD2;
      RD2:     w_state_nxt = LAST;
      LAST:    w_state_nxt = RESP;
      RESP:    if (resp_ready_i) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (flush_i) w_state_nxt = IDLE;
  end

  // Memory data lags the strobe by one cycle, so each byte lands one state after its read.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mem_addr <= '0;
      r_data     <= '0;
    end else if (!flush_i) begin
      case (r_state)
        IDLE: if (req_valid_i) r_mem_addr <= req_addr_i;
        RD0:  r_mem_addr <= r_mem_addr + MEM_ADDR_SIZE'(1);
        RD1: begin
          r_mem_addr          <= r_mem_addr + MEM_ADDR_SIZE'(1);
          r_data[BYTE-1:0]    <= mem_data_i;
        end
        RD2:  r_data[2*BYTE-1:BYTE]   <= mem_data_i;
        LAST: r_data[3*BYTE-1:2*BYTE] <= mem_data_i;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed bench for imem_fetch_responder with an inline 1-cycle-latency byte memory.
module tb_imem_fetch_responder;
  import nes_cpu_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      flush = 1'b0;
  logic                      req_valid = 1'b0;
  logic                      req_ready;
  logic [MEM_ADDR_SIZE-1:0]  req_addr = '0;
  logic                      mem_rd_en;
  logic [MEM_ADDR_SIZE-1:0]  mem_addr;
  logic [BYTE-1:0]           mem_rdata = '0;
  logic                      resp_valid;
  logic                      resp_ready = 1'b1;
  logic [FETCH_BUNDLE_W-1:0] resp_data;

  logic [BYTE-1:0] mem [0:65535];
  int n_vec = 0;
  int n_err = 0;

  imem_fetch_responder dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_i      (flush),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_addr_i   (req_addr),
    .mem_rd_en_o  (mem_rd_en),
    .mem_addr_o   (mem_addr),
    .mem_data_i   (mem_rdata),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_data_o  (resp_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    n_vec++; if (mem_rd_en !== 1'b0) begin n_err++; $display("FAIL reset_rd_en got %b want 0", mem_rd_en); end
    n_vec++; if (mem_addr !== 16'h0000) begin n_err++; $display("FAIL reset_mem_addr got %h want 0000", mem_addr); end
    n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
    n_vec++; if (resp_data !== 24'h000000) begin n_err++; $display("FAIL reset_resp_data got %h want 000000", resp_data); end
  endtask

  task automatic test_basic();
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_addr   = 16'h0200;
    tick();
    req_valid = 1'b0;
    n_vec++; if (mem_rd_en !== 1'b1 || mem_addr !== 16'h0200) begin n_err++; $display("FAIL basic_rd0 got en=%b addr=%h want en=1 addr=0200", mem_rd_en, mem_addr); end
    n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL basic_busy_ready got %b want 0", req_ready); end
    tick();
    n_vec++; if (mem_rd_en !== 1'b1 || mem_addr !== 16'h0201) begin n_err++; $display("FAIL basic_rd1 got en=%b addr=%h want en=1 addr=0201", mem_rd_en, mem_addr); end
    tick();
    n_vec++; if (mem_rd_en !== 1'b1 || mem_addr !== 16'h0202) begin n_err++; $display("FAIL basic_rd2 got en=%b addr=%h want en=1 addr=0202", mem_rd_en, mem_addr); end
    tick();
    n_vec++; if (mem_rd_en !== 1'b0 || resp_valid !== 1'b0) begin n_err++; $display("FAIL basic_last got en=%b vld=%b want en=0 vld=0", mem_rd_en, resp_valid); end
    tick();
    n_vec++; if (resp_valid !== 1'b1 || resp_data !== 24'h0042A9) begin n_err++; $display("FAIL basic_resp got vld=%b data=%h want vld=1 data=0042a9", resp_valid, resp_data); end
    tick();
    n_vec++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_err++; $display("FAIL basic_idle got vld=%b rdy=%b want vld=0 rdy=1", resp_valid, req_ready); end
  endtask

  task automatic test_wrap();
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_addr   = 16'hFFFF;
    tick();
    req_valid = 1'b0;
    n_vec++; if (mem_addr !== 16'hFFFF) begin n_err++; $display("FAIL wrap_rd0 got %h want ffff", mem_addr); end
    tick();
    n_vec++; if (mem_addr !== 16'h0000) begin n_err++; $display("FAIL wrap_rd1 got %h want 0000", mem_addr); end
    tick();
    n_vec++; if (mem_addr !== 16'h0001) begin n_err++; $display("FAIL wrap_rd2 got %h want 0001", mem_addr); end
    tick();
    tick();
    n_vec++; if (resp_valid !== 1'b1 || resp_data !== 24'h2211EA) begin n_err++; $display("FAIL wrap_resp got vld=%b data=%h want vld=1 data=2211ea", resp_valid, resp_data); end
    tick();
  endtask

  task automatic test_backpressure();
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_addr   = 16'h0040;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (resp_valid !== 1'b1 || resp_data !== 24'h181B1A || req_ready !== 1'b0) begin
        n_err++; $display("FAIL bp_hold cyc=%0d got vld=%b data=%h rdy=%b want vld=1 data=181b1a rdy=0", i, resp_valid, resp_data, req_ready);
      end
      tick();
    end
    resp_ready = 1'b1;
    n_vec++; if (resp_valid !== 1'b1 || resp_data !== 24'h181B1A) begin n_err++; $display("FAIL bp_release got vld=%b data=%h want vld=1 data=181b1a", resp_valid, resp_data); end
    tick();
    n_vec++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_err++; $display("FAIL bp_idle got vld=%b rdy=%b want vld=0 rdy=1", resp_valid, req_ready); end
  endtask

  task automatic test_flush();
    int seen;
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_addr   = 16'h0100;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    n_vec++; if (req_ready !== 1'b1 || mem_rd_en !== 1'b0) begin n_err++; $display("FAIL flush_idle got rdy=%b en=%b want rdy=1 en=0", req_ready, mem_rd_en); end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (resp_valid === 1'b1) seen++;
      tick();
    end
    n_vec++; if (seen != 0) begin n_err++; $display("FAIL flush_no_resp got %0d valid cycles want 0", seen); end
    // Flush in IDLE must block acceptance of a pending request.
    flush     = 1'b1;
    req_valid = 1'b1;
    req_addr  = 16'h0300;
    #1;
    n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL flush_idle_ready got %b want 0", req_ready); end
    tick();
    flush = 1'b0;
    n_vec++; if (mem_rd_en !== 1'b0) begin n_err++; $display("FAIL flush_idle_accept got en=%b want 0", mem_rd_en); end
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    n_vec++; if (resp_valid !== 1'b1 || resp_data !== 24'h030201) begin n_err++; $display("FAIL flush_new_resp got vld=%b data=%h want vld=1 data=030201", resp_valid, resp_data); end
    tick();
  endtask

  task automatic test_reset_mid();
    int seen;
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_addr   = 16'h0050;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    n_vec++; if (req_ready !== 1'b1 || mem_rd_en !== 1'b0 || mem_addr !== 16'h0000 || resp_valid !== 1'b0 || resp_data !== 24'h000000) begin
      n_err++; $display("FAIL rst_mid got rdy=%b en=%b addr=%h vld=%b data=%h want rdy=1 en=0 addr=0000 vld=0 data=000000", req_ready, mem_rd_en, mem_addr, resp_valid, resp_data);
    end
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (resp_valid === 1'b1) seen++;
    end
    n_vec++; if (seen != 0) begin n_err++; $display("FAIL rst_no_resp got %0d valid cycles want 0", seen); end
  endtask

  task automatic test_back_to_back();
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_addr   = 16'h0010;
    tick();
    req_addr = 16'h0013;
    for (int i = 0; i < 4; i++) tick();
    n_vec++; if (resp_valid !== 1'b1 || resp_data !== 24'h484B4A) begin n_err++; $display("FAIL b2b_first got vld=%b data=%h want vld=1 data=484b4a", resp_valid, resp_data); end
    tick();
    n_vec++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_err++; $display("FAIL b2b_gap got rdy=%b vld=%b want rdy=1 vld=0", req_ready, resp_valid); end
    tick();
    req_valid = 1'b0;
    n_vec++; if (mem_rd_en !== 1'b1 || mem_addr !== 16'h0013) begin n_err++; $display("FAIL b2b_second_rd0 got en=%b addr=%h want en=1 addr=0013", mem_rd_en, mem_addr); end
    for (int i = 0; i < 4; i++) tick();
    n_vec++; if (resp_valid !== 1'b1 || resp_data !== 24'h4F4E49) begin n_err++; $display("FAIL b2b_second got vld=%b data=%h want vld=1 data=4f4e49", resp_valid, resp_data); end
    tick();
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[16'h0200] = 8'hA9; mem[16'h0201] = 8'h42; mem[16'h0202] = 8'h00;
    mem[16'hFFFF] = 8'hEA; mem[16'h0000] = 8'h11; mem[16'h0001] = 8'h22;
    mem[16'h0300] = 8'h01; mem[16'h0301] = 8'h02; mem[16'h0302] = 8'h03;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/imem_fetch_responder.md
# imem_fetch_responder

Memory-side responder for the fetch stage's instruction request. It takes a byte address, performs three sequential reads from the byte-wide synchronous program memory, and returns the opcode byte plus two operand bytes as one 24-bit bundle through a valid/ready response. It sits between the fetch stage and the program memory, hiding the 8-bit memory width from the pipeline.

## Interface
- MEM_ADDR_SIZE, 16: byte address width; also the address wrap modulus (2^MEM_ADDR_SIZE).
- BYTE, 8: data byte width; the bundle width is 3*BYTE.

- clk_i  in  1  single clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- flush_i  in  1  abort any in-flight transaction (branch/redirect).
- req_valid_i  in  1  fetch request present.
- req_ready_o  out  1  responder can accept a request.
- req_addr_i  in  MEM_ADDR_SIZE  address of the opcode byte.
- mem_rd_en_o  out  1  byte read strobe to program memory.
- mem_addr_o  out  MEM_ADDR_SIZE  byte read address.
- mem_data_i  in  BYTE  read data, valid exactly 1 cycle after the mem_rd_en_o cycle.
- resp_valid_o  out  1  bundle valid.
- resp_ready_i  in  1  fetch stage accepts the bundle.
- resp_data_o  out  3*BYTE  {byte A+2, byte A+1, byte A}; opcode in [BYTE-1:0].

## Operation
- FSM states: IDLE, RD0, RD1, RD2, LAST, RESP. Reset and flush both go to IDLE.
- req_ready_o = (state==IDLE) && !flush_i.
- IDLE: when req_valid_i && req_ready_o, latch A=req_addr_i and go to RD0.
- RD0: mem_rd_en_o=1, mem_addr_o=A; go to RD1.
- RD1: issue A+1; capture mem_data_i into byte0; go to RD2.
- RD2: issue A+2; capture byte1; go to LAST.
- LAST: no read; capture byte2; go to RESP.
- RESP: resp_valid_o=1. On resp_ready_i, go to IDLE.
- Address arithmetic is modulo 2^MEM_ADDR_SIZE. A=0xFFFF reads 0xFFFF, 0x0000, 0x0001.
- resp_data_o is registered and stays stable while resp_valid_o && !resp_ready_i.
- mem_rd_en_o is 0 outside RD0–RD2. mem_addr_o holds its last value when not reading.
- flush_i in any state: go to IDLE next cycle and produce no response. Data returning for an aborted read is ignored.
- flush_i in RESP with resp_ready_i: flush wins, and the consumer discards the bundle.
- flush_i in IDLE with req_valid_i: the request is not accepted.
- rst_i mid-transaction: same effect as flush. Reset has priority over flush.

## Timing
- Reset values:
  - state IDLE
  - req_ready_o 1 (first cycle after reset with flush_i=0)
  - mem_rd_en_o 0
  - mem_addr_o 0
  - resp_valid_o 0
  - resp_data_o 0
- Request accepted at edge T:
  - reads issued in cycles T+1, T+2, T+3
  - bytes captured at the edges ending T+2, T+3, T+4
  - resp_valid_o high from cycle T+5
- Latency is 5 cycles from accept to valid when resp_ready_i is already high.
- The next request can be accepted in the cycle after the response handshake. Minimum period is 6 cycles per fetch.
- No combinational path from req_valid_i or resp_ready_i to any output except req_ready_o (which depends on flush_i).

## Structure
- nes_cpu_pkg holds:
  - MEM_ADDR_SIZE and BYTE
  - FETCH_BUNDLE_W = 3*BYTE
  - typedef enum fetch_rsp_state_t {IDLE, RD0, RD1, RD2, LAST, RESP}
- Single flat module with no sub-module. The bench provides a byte_mem_model (synchronous read, 1-cycle latency).

## Test plan
- Memory 0x0200..0x0202 = A9, 42, 00; request 0x0200 at T -> reads at T+1..T+3 on 0x0200/0x0201/0x0202, resp_data_o=0x0042A9 valid at T+5.
- Request 0xFFFF with mem[0xFFFF]=EA, mem[0x0000]=11, mem[0x0001]=22 -> addresses 0xFFFF, 0x0000, 0x0001; resp_data_o=0x2211EA.
- resp_ready_i low for 4 cycles in RESP -> resp_valid_o and data held stable; req_ready_o stays 0; IDLE the cycle after the handshake.
- flush_i pulsed in RD2 -> no response; req_ready_o=1 next cycle; a new request to 0x0300 returns the correct bundle with no stale bytes.
- rst_i asserted in LAST -> next cycle all outputs at reset values; resp_valid_o never asserted for the aborted fetch.
- Back-to-back requests 0x0010 and 0x0013 with req_valid_i held high -> second accepted the cycle after the first handshake; two correct bundles in order.
